// File: rtl/uart_core.sv
// uart_core: register-mapped 8N1 UART with programmable baud divisor and level interrupt
module uart_core #(
  parameter logic [15:0] DIV_RESET = 16'd103
) (
  input  logic       clk,
  input  logic       reset,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       interrupt,
  input  logic [4:0] reg_addr,
  input  logic [7:0] reg_data_in,
  input  logic       reg_write,
  input  logic       reg_read,
  output logic [7:0] reg_data_out
);
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;
  logic [15:0] div, eff_div, tx_cnt, tx_cnt_next, rx_cnt, rx_cnt_next;
  logic [7:0] tx_hold, tx_shift, tx_shift_next, rx_hold, rx_shift, rx_shift_next;
  logic [2:0] tx_bit, tx_bit_next, rx_bit, rx_bit_next, en;
  logic [1:0] rx_sync;
  logic tx_full, rx_valid, overrun, frame_err, tx_load, rx_done, rx_s, tx_busy, pop, wr_tx, wr_st;
  assign eff_div = div < 16'd3 ? 16'd3 : div;
  assign rx_s = rx_sync[1];
  assign tx_busy = tx_state != TX_IDLE;
  assign pop = reg_read && reg_addr == 5'd0;
  assign wr_tx = reg_write && reg_addr == 5'd0;
  assign wr_st = reg_write && reg_addr == 5'd1;
  assign uart_tx = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_shift[0] : 1'b1;
  assign interrupt = (en[0] & rx_valid) | (en[1] & ~tx_full) | (en[2] & (overrun | frame_err));
  assign reg_data_out = reg_addr == 5'd0 ? rx_hold :
                        reg_addr == 5'd1 ? {3'b0, frame_err, overrun, tx_busy, tx_full, rx_valid} :
                        reg_addr == 5'd2 ? {5'b0, en} :
                        reg_addr == 5'd3 ? div[7:0] :
                        reg_addr == 5'd4 ? div[15:8] : 8'h00;
  always_comb begin
    tx_next = tx_state;
    tx_cnt_next = tx_cnt - 16'd1;
    tx_shift_next = tx_shift;
    tx_bit_next = tx_bit;
    tx_load = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_next = tx_cnt;
        if (tx_full) begin
          tx_load = 1'b1;
          tx_next = TX_START;
          tx_cnt_next = eff_div;
          tx_shift_next = tx_hold;
        end
      end
      TX_START: if (tx_cnt == 16'd0) begin
        tx_next = TX_DATA;
        tx_cnt_next = eff_div;
        tx_bit_next = 3'd0;
      end
      TX_DATA: if (tx_cnt == 16'd0) begin
        tx_cnt_next = eff_div;
        tx_shift_next = {1'b0, tx_shift[7:1]};
        tx_bit_next = tx_bit + 3'd1;
        tx_next = tx_bit == 3'd7 ? TX_STOP : TX_DATA;
      end
      TX_STOP: if (tx_cnt == 16'd0) begin
        tx_load = tx_full;
        tx_next = tx_full ? TX_START : TX_IDLE;
        tx_cnt_next = eff_div;
        tx_shift_next = tx_full ? tx_hold : tx_shift;
      end
      default: tx_next = TX_IDLE;
    endcase
  end
  always_comb begin
    rx_next = rx_state;
    rx_cnt_next = rx_cnt - 16'd1;
    rx_shift_next = rx_shift;
    rx_bit_next = rx_bit;
    rx_done = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_next = eff_div >> 1;
        rx_next = rx_s ? RX_IDLE : RX_START;
      end
      RX_START: if (rx_cnt == 16'd0) begin
        rx_cnt_next = eff_div;
        rx_bit_next = 3'd0;
        rx_next = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == 16'd0) begin
        rx_cnt_next = eff_div;
        rx_shift_next = {rx_s, rx_shift[7:1]};
        rx_bit_next = rx_bit + 3'd1;
        rx_next = rx_bit == 3'd7 ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (rx_cnt == 16'd0) begin
        rx_done = 1'b1;
        rx_next = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: rx_next = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      default: rx_next = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      rx_state <= RX_IDLE;
      tx_cnt <= 16'd0;
      rx_cnt <= 16'd0;
      tx_shift <= 8'h00;
      rx_shift <= 8'h00;
      tx_bit <= 3'd0;
      rx_bit <= 3'd0;
      rx_sync <= 2'b11;
      div <= DIV_RESET;
      en <= 3'd0;
      tx_hold <= 8'h00;
      rx_hold <= 8'h00;
      tx_full <= 1'b0;
      rx_valid <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
      tx_cnt <= tx_cnt_next;
      rx_cnt <= rx_cnt_next;
      tx_shift <= tx_shift_next;
      rx_shift <= rx_shift_next;
      tx_bit <= tx_bit_next;
      rx_bit <= rx_bit_next;
      rx_sync <= {rx_sync[0], uart_rx};
      if (reg_write && reg_addr == 5'd2) en <= reg_data_in[2:0];
      if (reg_write && reg_addr == 5'd3) div[7:0] <= reg_data_in;
      if (reg_write && reg_addr == 5'd4) div[15:8] <= reg_data_in;
      if (wr_tx && !tx_full) begin
        tx_hold <= reg_data_in;
        tx_full <= 1'b1;
      end else if (tx_load) tx_full <= 1'b0;
      if (rx_done && (!rx_valid || pop)) begin
        rx_hold <= rx_shift;
        rx_valid <= 1'b1;
      end else if (pop) rx_valid <= 1'b0;
      overrun <= (rx_done && rx_valid && !pop) || (overrun && !(wr_st && reg_data_in[3]));
      frame_err <= (rx_done && !rx_s) || (frame_err && !(wr_st && reg_data_in[4]));
    end
  end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: scoreboard bench for uart_core; TX bytes decoded off the pin, RX bytes compared on read-out
module tb_uart_core;
  logic clk = 1'b0, reset = 1'b1, uart_rx = 1'b1, reg_write = 1'b0, reg_read = 1'b0;
  logic [4:0] reg_addr = 5'd0;
  logic [7:0] reg_data_in = 8'h00;
  logic uart_tx, interrupt;
  logic [7:0] reg_data_out;
  int checks = 0, errors = 0, cyc = 0, bit_clks = 10;
  logic [7:0] tx_exp[$], tx_got[$], rx_exp[$];
  int tx_start[$];

  uart_core #(.DIV_RESET(16'd103)) dut (
    .clk(clk), .reset(reset), .uart_tx(uart_tx), .uart_rx(uart_rx), .interrupt(interrupt),
    .reg_addr(reg_addr), .reg_data_in(reg_data_in), .reg_write(reg_write), .reg_read(reg_read),
    .reg_data_out(reg_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : tx_monitor
    int n;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        n = bit_clks;
        tx_start.push_back(cyc);
        repeat (n / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (n) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (n) @(negedge clk);
        tx_got.push_back(b);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_addr = a;
    reg_data_in = d;
    reg_write = 1'b1;
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    @(negedge clk);
    reg_addr = a;
    reg_read = 1'b1;
    #1 d = reg_data_out;
    @(negedge clk);
    reg_read = 1'b0;
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop, input int n, input int stop_extra);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (n) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (n) @(negedge clk);
    end
    uart_rx = stop;
    repeat (n + stop_extra) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    #1 reset = 1'b0;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_interrupt: got %b expected 0", interrupt); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd(5'd1, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", d); end
    rd(5'd3, d); checks++; if (d !== 8'h67) begin errors++; $display("FAIL reset_div_lo: got %h expected 67", d); end
    rd(5'd4, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_div_hi: got %h expected 00", d); end
    rd(5'd2, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_int_en: got %h expected 00", d); end
    rd(5'd0, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", d); end
    rd(5'd5, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL undefined_addr: got %h expected 00", d); end
  endtask

  task automatic test_tx_frame;
    logic [7:0] d, g, e, pat;
    logic ex;
    int bad_tx, bad_busy;
    wr(5'd3, 8'd9);
    wr(5'd4, 8'd0);
    rd(5'd3, d); checks++; if (d !== 8'd9) begin errors++; $display("FAIL div_write: got %h expected 09", d); end
    pat = 8'hA5;
    tx_exp.push_back(pat);
    wr(5'd0, pat);
    reg_addr = 5'd1;
    #1;
    checks++; if ({reg_data_out[1], uart_tx} !== 2'b11) begin errors++; $display("FAIL tx_full_after_write: got full=%b tx=%b expected full=1 tx=1", reg_data_out[1], uart_tx); end
    bad_tx = 0;
    bad_busy = 0;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      ex = k <= 10 ? 1'b0 : k <= 90 ? pat[(k - 11) / 10] : 1'b1;
      if (uart_tx !== ex) bad_tx++;
      if (reg_data_out[2] !== (k <= 100)) bad_busy++;
    end
    checks++; if (bad_tx != 0) begin errors++; $display("FAIL tx_waveform: got %0d bad cycles expected 0", bad_tx); end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL tx_busy_window: got %0d bad cycles expected 0", bad_busy); end
    checks++;
    if (tx_got.size() == 0) begin errors++; $display("FAIL tx_byte: got no frame expected %h", pat); end
    else begin
      g = tx_got.pop_front();
      e = tx_exp.pop_front();
      if (g !== e) begin errors++; $display("FAIL tx_byte: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d, g, e;
    logic done;
    tx_start.delete();
    tx_exp.push_back(8'h11);
    wr(5'd0, 8'h11);
    repeat (20) @(negedge clk);
    tx_exp.push_back(8'h22);
    wr(5'd0, 8'h22);
    rd(5'd1, d); checks++; if (d !== 8'h06) begin errors++; $display("FAIL b2b_status: got %h expected 06", d); end
    wr(5'd0, 8'h33);
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      reg_addr = 5'd1;
      #1 done = !reg_data_out[2];
    end
    checks++; if (!done) begin errors++; $display("FAIL b2b_idle_timeout: got busy expected idle within 400 clocks"); end
    repeat (5) @(negedge clk);
    checks++; if (tx_start.size() != 2 || tx_start[1] - tx_start[0] != 100) begin errors++; $display("FAIL b2b_spacing: got %0d starts expected 2 starts 100 clocks apart", tx_start.size()); end
    checks++; if (tx_got.size() != 2) begin errors++; $display("FAIL b2b_frame_count: got %0d expected 2", tx_got.size()); end
    while (tx_got.size() > 0 && tx_exp.size() > 0) begin
      g = tx_got.pop_front();
      e = tx_exp.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_byte: got %h expected %h", g, e); end
    end
    tx_got.delete();
    tx_exp.delete();
  endtask

  task automatic test_rx;
    logic [7:0] d;
    wr(5'd2, 8'h01);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rx_int_idle: got %b expected 0", interrupt); end
    rx_exp.push_back(8'h3C);
    drive_rx(8'h3C, 1'b1, 10, 0);
    repeat (3) @(negedge clk);
    rd(5'd1, d); checks++; if (d !== 8'h01) begin errors++; $display("FAIL rx_status: got %h expected 01", d); end
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL rx_int_set: got %b expected 1", interrupt); end
    rd(5'd0, d); checks++; if (d !== rx_exp.pop_front()) begin errors++; $display("FAIL rx_byte: got %h expected 3c", d); end
    rd(5'd1, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL rx_pop_clears: got %h expected 00", d); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rx_int_clear: got %b expected 0", interrupt); end
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    rx_exp.push_back(8'h5A);
    drive_rx(8'h5A, 1'b1, 10, 0);
    drive_rx(8'hC3, 1'b1, 10, 0);
    repeat (3) @(negedge clk);
    rd(5'd1, d); checks++; if (d !== 8'h09) begin errors++; $display("FAIL overrun_status: got %h expected 09", d); end
    rd(5'd0, d); checks++; if (d !== rx_exp.pop_front()) begin errors++; $display("FAIL overrun_keeps_first: got %h expected 5a", d); end
    wr(5'd1, 8'h08);
    rd(5'd1, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL overrun_w1c: got %h expected 00", d); end
  endtask

  task automatic test_glitch_frame_err;
    logic [7:0] d;
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    rd(5'd1, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL glitch_status: got %h expected 00", d); end
    rx_exp.push_back(8'h96);
    drive_rx(8'h96, 1'b0, 10, 40);
    repeat (120) @(negedge clk);
    rd(5'd1, d); checks++; if (d !== 8'h11) begin errors++; $display("FAIL frame_err_status: got %h expected 11", d); end
    rd(5'd0, d); checks++; if (d !== rx_exp.pop_front()) begin errors++; $display("FAIL frame_err_byte: got %h expected 96", d); end
    wr(5'd1, 8'h10);
    rd(5'd1, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL frame_err_w1c: got %h expected 00", d); end
  endtask

  task automatic test_div_min;
    logic [7:0] d, g, e;
    int lo;
    wr(5'd3, 8'd1);
    rd(5'd3, d); checks++; if (d !== 8'd1) begin errors++; $display("FAIL div_min_readback: got %h expected 01", d); end
    bit_clks = 4;
    tx_exp.push_back(8'h55);
    wr(5'd0, 8'h55);
    for (int w = 0; w < 20 && uart_tx !== 1'b0; w++) @(negedge clk);
    lo = 0;
    while (uart_tx === 1'b0 && lo < 50) begin
      lo++;
      @(negedge clk);
    end
    checks++; if (lo != 4) begin errors++; $display("FAIL div_min_start_len: got %0d expected 4", lo); end
    repeat (60) @(negedge clk);
    checks++;
    if (tx_got.size() == 0) begin errors++; $display("FAIL div_min_byte: got no frame expected 55"); end
    else begin
      g = tx_got.pop_front();
      e = tx_exp.pop_front();
      if (g !== e) begin errors++; $display("FAIL div_min_byte: got %h expected %h", g, e); end
    end
    wr(5'd3, 8'd9);
    bit_clks = 10;
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    wr(5'd2, 8'h07);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL txempty_int: got %b expected 1", interrupt); end
    wr(5'd0, 8'h00);
    uart_rx = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if ({uart_tx, interrupt} !== 2'b01) begin errors++; $display("FAIL mid_frame_pre: got tx=%b int=%b expected tx=0 int=1", uart_tx, interrupt); end
    #2 reset = 1'b0;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL mid_reset_uart_tx: got %b expected 1", uart_tx); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL mid_reset_interrupt: got %b expected 0", interrupt); end
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd(5'd3, d); checks++; if (d !== 8'h67) begin errors++; $display("FAIL post_reset_div_lo: got %h expected 67", d); end
    rd(5'd4, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL post_reset_div_hi: got %h expected 00", d); end
    rd(5'd1, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL post_reset_status: got %h expected 00", d); end
    repeat (120) @(negedge clk);
    tx_got.delete();
    tx_exp.delete();
    tx_start.delete();
    rx_exp.push_back(8'hE1);
    drive_rx(8'hE1, 1'b1, 104, 0);
    repeat (5) @(negedge clk);
    rd(5'd1, d); checks++; if (d !== 8'h01) begin errors++; $display("FAIL post_reset_rx_status: got %h expected 01", d); end
    rd(5'd0, d); checks++; if (d !== rx_exp.pop_front()) begin errors++; $display("FAIL post_reset_rx_byte: got %h expected e1", d); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_rx();
    test_overrun();
    test_glitch_frame_err();
    test_div_min();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
